// File: rtl/decode_queue_pkg.sv
// Shared definitions for the decode stage: micro-op codes, RV32I(M) major
// opcodes and the packed payloads carried through the decoded-op queue.
package decode_queue_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 6;

  // OP_NOP must stay at zero: cleared storage reads back as a NOP entry.
  typedef enum logic [OPW-1:0] {
    OP_NOP = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } oper_t;

  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] L_TYPE = 7'b0000011;
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] S_TYPE = 7'b0100011;
  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef struct packed {
    oper_t           op;
    logic [XLEN-1:0] imm;
    logic            en_rx;
    logic            en_ry;
    logic            en_w;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic            illegal;
  } uop_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    uop_t            uop;
  } entry_t;

endpackage

// File: rtl/inst_decode.sv
// Combinational RV32I(M) decoder.
// Ports: inst (instruction word) -> uop (op, immediate, enables,
// register addresses, illegal flag). EN_RVM enables M-extension decode.
module inst_decode
  import decode_queue_pkg::*;
#(
  parameter bit EN_RVM = 1'b0
) (
  input  logic [31:0] inst,
  output uop_t        uop
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  oper_t       op;
  logic [31:0] imm;
  logic        rx, ry, w, bad;

  // Opcode/funct decode; anything unrecognised collapses to an illegal NOP.
  always_comb begin
    op  = OP_NOP;
    imm = '0;
    rx  = 1'b0;
    ry  = 1'b0;
    w   = 1'b0;
    bad = 1'b0;
    case (opc)
      I_TYPE: begin
        rx = 1'b1; w = 1'b1; imm = imm_i;
        case (f3)
          3'b000: op = OP_ADDI;
          3'b010: op = OP_SLTI;
          3'b011: op = OP_SLTIU;
          3'b100: op = OP_XORI;
          3'b110: op = OP_ORI;
          3'b111: op = OP_ANDI;
          3'b001: if (f7 == 7'b0000000) op = OP_SLLI; else bad = 1'b1;
          3'b101: begin
            if (f7 == 7'b0000000)      op = OP_SRLI;
            else if (f7 == 7'b0100000) op = OP_SRAI;
            else                       bad = 1'b1;
          end
        endcase
      end
      L_TYPE: begin
        rx = 1'b1; w = 1'b1; imm = imm_i;
        case (f3)
          3'b000:  op = OP_LB;
          3'b001:  op = OP_LH;
          3'b010:  op = OP_LW;
          3'b100:  op = OP_LBU;
          3'b101:  op = OP_LHU;
          default: bad = 1'b1;
        endcase
      end
      R_TYPE: begin
        rx = 1'b1; ry = 1'b1; w = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: op = OP_ADD;
            3'b001: op = OP_SLL;
            3'b010: op = OP_SLT;
            3'b011: op = OP_SLTU;
            3'b100: op = OP_XOR;
            3'b101: op = OP_SRL;
            3'b110: op = OP_OR;
            3'b111: op = OP_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'b000:  op = OP_SUB;
            3'b101:  op = OP_SRA;
            default: bad = 1'b1;
          endcase
        end else if (EN_RVM && (f7 == 7'b0000001)) begin
          case (f3)
            3'b000: op = OP_MUL;
            3'b001: op = OP_MULH;
            3'b010: op = OP_MULHSU;
            3'b011: op = OP_MULHU;
            3'b100: op = OP_DIV;
            3'b101: op = OP_DIVU;
            3'b110: op = OP_REM;
            3'b111: op = OP_REMU;
          endcase
        end else begin
          bad = 1'b1;
        end
      end
      S_TYPE: begin
        rx = 1'b1; ry = 1'b1; imm = imm_s;
        case (f3)
          3'b000:  op = OP_SB;
          3'b001:  op = OP_SH;
          3'b010:  op = OP_SW;
          default: bad = 1'b1;
        endcase
      end
      B_TYPE: begin
        rx = 1'b1; ry = 1'b1; imm = imm_b;
        case (f3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: bad = 1'b1;
        endcase
      end
      LUI:   begin op = OP_LUI;   w = 1'b1; imm = imm_u; end
      AUIPC: begin op = OP_AUIPC; w = 1'b1; imm = imm_u; end
      JAL:   begin op = OP_JAL;   w = 1'b1; imm = imm_j; end
      JALR: begin
        rx = 1'b1; w = 1'b1; imm = imm_i;
        if (f3 == 3'b000) op = OP_JALR; else bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      op  = OP_NOP;
      imm = '0;
      rx  = 1'b0;
      ry  = 1'b0;
      w   = 1'b0;
    end
    // Writes to x0 are architecturally discarded.
    if (inst[11:7] == 5'd0) w = 1'b0;
  end

  // Unused register fields are zeroed so the queue payload is deterministic.
  assign uop.op      = op;
  assign uop.imm     = imm;
  assign uop.en_rx   = rx;
  assign uop.en_ry   = ry;
  assign uop.en_w    = w;
  assign uop.rs1     = rx ? inst[19:15] : 5'd0;
  assign uop.rs2     = ry ? inst[24:20] : 5'd0;
  assign uop.rd      = w  ? inst[11:7]  : 5'd0;
  assign uop.illegal = bad;

endmodule

// File: rtl/decode_queue.sv
// Instruction-decode stage with a DEPTH-entry decoded-op FIFO.
// Ports: clk, rst_n, rdy (global enable), flush; fetch side in_valid/
// in_ready/in_pc/in_inst; issue side out_valid/out_ready and the head
// entry fields out_pc, out_op, out_imm, out_en_rx/ry/w, out_rs1/rs2/rd,
// out_illegal.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter bit          EN_RVM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output oper_t       out_op,
  output logic [31:0] out_imm,
  output logic        out_en_rx,
  output logic        out_en_ry,
  output logic        out_en_w,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  entry_t        mem [DEPTH];
  uop_t          dec;
  entry_t        head_e;
  logic          push, pop;

  inst_decode #(.EN_RVM(EN_RVM)) u_dec (
    .inst (in_inst),
    .uop  (dec)
  );

  // No pop-through: a full queue refuses input even while popping.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & rdy & ~flush;
  assign pop       = out_valid & out_ready & rdy & ~flush;

  // Entry storage; cleared on reset so an empty queue presents a NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[PW'(i)] <= '0;
    end else if (push) begin
      mem[tail] <= '{pc: in_pc, uop: dec};
    end
  end

  // Pointers and occupancy; flush rewinds both pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  assign head_e      = mem[head];
  assign out_pc      = head_e.pc;
  assign out_op      = head_e.uop.op;
  assign out_imm     = head_e.uop.imm;
  assign out_en_rx   = head_e.uop.en_rx;
  assign out_en_ry   = head_e.uop.en_ry;
  assign out_en_w    = head_e.uop.en_w;
  assign out_rs1     = head_e.uop.rs1;
  assign out_rs2     = head_e.uop.rs2;
  assign out_rd      = head_e.uop.rd;
  assign out_illegal = head_e.uop.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: scoreboard of expected entries, one task per scenario.
module tb_decode_queue;
  import decode_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, rdy, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_inst;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  oper_t       out_op;
  logic        out_en_rx, out_en_ry, out_en_w, out_illegal;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  logic        m_in_ready, m_out_valid;
  logic [31:0] m_out_pc, m_out_imm;
  oper_t       m_out_op;
  logic        m_out_en_rx, m_out_en_ry, m_out_en_w, m_out_illegal;
  logic [4:0]  m_out_rs1, m_out_rs2, m_out_rd;

  int     checks = 0;
  int     failures = 0;
  int     mcount = 0;
  entry_t sb[$];
  entry_t obs, want;

  localparam logic [31:0] I_ADDI = 32'hFFF10093;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h40628233;
  localparam logic [31:0] I_XORI = 32'h7FF44393;
  localparam logic [31:0] I_MUL  = 32'h023100B3;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(2), .EN_RVM(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_imm(out_imm), .out_en_rx(out_en_rx), .out_en_ry(out_en_ry), .out_en_w(out_en_w),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  decode_queue #(.DEPTH(2), .EN_RVM(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(m_in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_pc(m_out_pc), .out_op(m_out_op),
    .out_imm(m_out_imm), .out_en_rx(m_out_en_rx), .out_en_ry(m_out_en_ry), .out_en_w(m_out_en_w),
    .out_rs1(m_out_rs1), .out_rs2(m_out_rs2), .out_rd(m_out_rd), .out_illegal(m_out_illegal)
  );

  assign obs = {out_pc, out_op, out_imm, out_en_rx, out_en_ry, out_en_w,
                out_rs1, out_rs2, out_rd, out_illegal};

  function automatic entry_t mk(input logic [31:0] pc, input oper_t op, input logic [31:0] imm,
                                input logic rx, input logic ry, input logic w,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic ill);
    entry_t e;
    e.pc = pc; e.uop.op = op; e.uop.imm = imm;
    e.uop.en_rx = rx; e.uop.en_ry = ry; e.uop.en_w = w;
    e.uop.rs1 = rs1; e.uop.rs2 = rs2; e.uop.rd = rd; e.uop.illegal = ill;
    return e;
  endfunction

  // Drive one cycle; the occupancy model decides whether e enters the scoreboard.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input entry_t e, input logic ordy, input logic fl, input logic r);
    bit push_m, pop_m;
    in_valid = v; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl; rdy = r;
    push_m = v && (mcount < 2) && r && !fl;
    pop_m  = (mcount != 0) && ordy && r && !fl;
    @(posedge clk); #1;
    if (r && fl) begin
      mcount = 0;
      sb.delete();
    end else begin
      if (push_m) sb.push_back(e);
      mcount = mcount + int'(push_m) - int'(pop_m);
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; rdy = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (obs !== entry_t'(0)) begin failures++; $display("FAIL reset_entry: got %h want 0", obs); end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    cyc(1'b1, 32'h100, I_ADDI, mk(32'h100, OP_ADDI, 32'hFFFFFFFF, 1, 0, 1, 5'd2, 5'd0, 5'd1, 0), 1'b0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", out_valid); end
    want = sb.pop_front();
    checks++; if (obs !== want) begin failures++; $display("FAIL single_entry: got %h want %h", obs, want); end
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_back_pressure;
    entry_t e_add, e_sub, e_xori;
    e_add  = mk(32'h200, OP_ADD,  32'h0,   1, 1, 1, 5'd1, 5'd2, 5'd3, 0);
    e_sub  = mk(32'h204, OP_SUB,  32'h0,   1, 1, 1, 5'd5, 5'd6, 5'd4, 0);
    e_xori = mk(32'h208, OP_XORI, 32'h7FF, 1, 0, 1, 5'd8, 5'd0, 5'd7, 0);
    cyc(1'b1, 32'h200, I_ADD, e_add, 1'b0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
    cyc(1'b1, 32'h204, I_SUB, e_sub, 1'b0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2: got %b want 0", in_ready); end
    cyc(1'b1, 32'h208, I_XORI, e_xori, 1'b0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_held: got ready=%b valid=%b want ready=0 valid=1", in_ready, out_valid); end
    // Full with both sides active: pop happens, push is refused.
    want = sb.pop_front();
    checks++; if (obs !== want) begin failures++; $display("FAIL bp_head_add: got %h want %h", obs, want); end
    cyc(1'b1, 32'h208, I_XORI, e_xori, 1'b1, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL full_pop_no_push: got ready=%b valid=%b want ready=1 valid=1", in_ready, out_valid); end
    want = sb.pop_front();
    checks++; if (obs !== want) begin failures++; $display("FAIL bp_head_sub: got %h want %h", obs, want); end
    cyc(1'b1, 32'h208, I_XORI, e_xori, 1'b1, 1'b0, 1'b1);
    want = sb.pop_front();
    checks++; if (obs !== want) begin failures++; $display("FAIL bp_head_xori: got %h want %h", obs, want); end
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_immediates;
    logic [31:0] ins [5];
    entry_t      ex  [5];
    ins[0] = 32'h12345297; ex[0] = mk(32'h300, OP_AUIPC, 32'h12345000, 0, 0, 1, 5'd0, 5'd0, 5'd5, 0);
    ins[1] = 32'hFFDFF0EF; ex[1] = mk(32'h304, OP_JAL,   32'hFFFFFFFC, 0, 0, 1, 5'd0, 5'd0, 5'd1, 0);
    ins[2] = 32'hFE312C23; ex[2] = mk(32'h308, OP_SW,    32'hFFFFFFF8, 1, 1, 0, 5'd2, 5'd3, 5'd0, 0);
    ins[3] = 32'hFE208CE3; ex[3] = mk(32'h30C, OP_BEQ,   32'hFFFFFFF8, 1, 1, 0, 5'd1, 5'd2, 5'd0, 0);
    ins[4] = 32'h00001037; ex[4] = mk(32'h310, OP_LUI,   32'h00001000, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // Back-to-back: push one and pop one every cycle.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        want = sb.pop_front();
        checks++; if (obs !== want) begin failures++; $display("FAIL imm_%0d: got %h want %h", i - 1, obs, want); end
      end
      cyc(1'b1, ex[i].pc, ins[i], ex[i], i > 0, 1'b0, 1'b1);
    end
    want = sb.pop_front();
    checks++; if (obs !== want) begin failures++; $display("FAIL imm_4: got %h want %h", obs, want); end
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_rvm;
    cyc(1'b1, 32'h400, I_MUL, mk(32'h400, OP_NOP, 32'h0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h404, 32'h0000007F, mk(32'h404, OP_NOP, 32'h0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1), 1'b0, 1'b0, 1'b1);
    checks++; if (m_out_op !== OP_MUL || m_out_illegal !== 1'b0) begin failures++; $display("FAIL rvm_mul_decode: got op=%0d ill=%b want op=%0d ill=0", m_out_op, m_out_illegal, OP_MUL); end
    want = sb.pop_front();
    checks++; if (obs !== want) begin failures++; $display("FAIL norvm_mul_illegal: got %h want %h", obs, want); end
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    checks++; if (m_out_illegal !== 1'b1) begin failures++; $display("FAIL rvm_opc7f_illegal: got %b want 1", m_out_illegal); end
    want = sb.pop_front();
    checks++; if (obs !== want) begin failures++; $display("FAIL opc7f_illegal: got %h want %h", obs, want); end
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_flush;
    cyc(1'b1, 32'h500, I_ADD, mk(32'h500, OP_ADD, 32'h0, 1, 1, 1, 5'd1, 5'd2, 5'd3, 0), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h504, I_SUB, mk(32'h504, OP_SUB, 32'h0, 1, 1, 1, 5'd5, 5'd6, 5'd4, 0), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h508, I_XORI, mk(32'h508, OP_XORI, 32'h7FF, 1, 0, 1, 5'd8, 5'd0, 5'd7, 0), 1'b1, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_empty: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready); end
    cyc(1'b1, 32'h50C, I_ADDI, mk(32'h50C, OP_ADDI, 32'hFFFFFFFF, 1, 0, 1, 5'd2, 5'd0, 5'd1, 0), 1'b0, 1'b0, 1'b1);
    want = sb.pop_front();
    checks++; if (obs !== want) begin failures++; $display("FAIL flush_repush: got %h want %h", obs, want); end
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_flush_rdy0;
    cyc(1'b1, 32'h600, I_ADD, mk(32'h600, OP_ADD, 32'h0, 1, 1, 1, 5'd1, 5'd2, 5'd3, 0), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h604, I_SUB, mk(32'h604, OP_SUB, 32'h0, 1, 1, 1, 5'd5, 5'd6, 5'd4, 0), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h608, I_XORI, mk(32'h608, OP_XORI, 32'h7FF, 1, 0, 1, 5'd8, 5'd0, 5'd7, 0), 1'b1, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL rdy0_hold: got valid=%b ready=%b want valid=1 ready=0", out_valid, in_ready); end
    for (int i = 0; i < 2; i++) begin
      want = sb.pop_front();
      checks++; if (obs !== want) begin failures++; $display("FAIL rdy0_drain_%0d: got %h want %h", i, obs, want); end
      cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rdy0_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    cyc(1'b1, 32'h700, I_ADD, mk(32'h700, OP_ADD, 32'h0, 1, 1, 1, 5'd1, 5'd2, 5'd3, 0), 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || obs !== entry_t'(0)) begin failures++; $display("FAIL async_reset: got valid=%b entry=%h want valid=0 entry=0", out_valid, obs); end
    sb.delete();
    mcount = 0;
    #1 rst_n = 1'b1;
    cyc(1'b1, 32'h704, I_ADDI, mk(32'h704, OP_ADDI, 32'hFFFFFFFF, 1, 0, 1, 5'd2, 5'd0, 5'd1, 0), 1'b0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL post_reset_push: got %b want 1", out_valid); end
    want = sb.pop_front();
    checks++; if (obs !== want) begin failures++; $display("FAIL post_reset_entry: got %h want %h", obs, want); end
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_pressure;
    test_immediates;
    test_rvm;
    test_flush;
    test_flush_rdy0;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
